// File: rtl/vmicro16_apb_master_pkg.sv
// Shared widths and helpers for the vmicro16 APB initiator.
package vmicro16_apb_master_pkg;
  localparam int APB_WIDTH  = 24;
  localparam int DATA_WIDTH = 16;

  // Wait counter must hold TIMEOUT itself; a zero TIMEOUT still needs one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction
endpackage

// File: rtl/vmicro16_apb_decode.sv
// Slave-index decode: index field -> one-hot PSEL vector plus in-range flag.
module vmicro16_apb_decode #(
  parameter int SLAVES   = 8,
  parameter int SEL_BITS = 4
) (
  input  logic [SEL_BITS-1:0] idx,
  output logic [SLAVES-1:0]   sel,
  output logic                valid
);
  assign valid = int'(idx) < SLAVES;

  for (genvar i = 0; i < SLAVES; i++) begin : g_sel
    assign sel[i] = (int'(idx) == i);
  end
endmodule

// File: rtl/vmicro16_apb_master.sv
// APB initiator: single-outstanding core request -> SETUP/ACCESS on the peripheral bus.
module vmicro16_apb_master
  import vmicro16_apb_master_pkg::*;
#(
  parameter int SLAVES    = 8,
  parameter int SEL_SHIFT = 12,
  parameter int SEL_BITS  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         M_REQ,
  input  logic                         M_WE,
  input  logic [APB_WIDTH-1:0]         M_ADDR,
  input  logic [DATA_WIDTH-1:0]        M_WDATA,
  output logic                         M_ACK,
  output logic [DATA_WIDTH-1:0]        M_RDATA,
  output logic                         M_ERR,
  output logic                         M_BUSY,
  output logic [APB_WIDTH-1:0]         M_PADDR,
  output logic                         M_PWRITE,
  output logic [SLAVES-1:0]            M_PSELx,
  output logic                         M_PENABLE,
  output logic [DATA_WIDTH-1:0]        M_PWDATA,
  input  logic [SLAVES*DATA_WIDTH-1:0] M_PRDATA,
  input  logic [SLAVES-1:0]            M_PREADY
);
  localparam int CW = cnt_width(TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_DERR   = 3'd4;

  logic [2:0]            state_q,   state_d;
  logic [CW-1:0]         cnt_q,     cnt_d;
  logic                  ack_q,     ack_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic                  err_q,     err_d;
  logic                  busy_q,    busy_d;
  logic [APB_WIDTH-1:0]  paddr_q,   paddr_d;
  logic                  pwrite_q,  pwrite_d;
  logic [SLAVES-1:0]     psel_q,    psel_d;
  logic                  penable_q, penable_d;
  logic [DATA_WIDTH-1:0] pwdata_q,  pwdata_d;

  logic [SLAVES-1:0]     dec_sel;
  logic                  dec_valid;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic [CW-1:0]         cnt_inc;

  vmicro16_apb_decode #(.SLAVES(SLAVES), .SEL_BITS(SEL_BITS)) u_decode (
    .idx   (M_ADDR[SEL_SHIFT +: SEL_BITS]),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  // The latched one-hot select doubles as the mux control, so only the
  // addressed slave's PREADY/PRDATA can ever reach the core.
  assign sel_ready = |(M_PREADY & psel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < SLAVES; i++)
      if (psel_q[i]) sel_rdata = sel_rdata | M_PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    rdata_d   = rdata_q;
    err_d     = err_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      S_IDLE: if (M_REQ) begin
        paddr_d  = M_ADDR;
        pwrite_d = M_WE;
        pwdata_d = M_WDATA;
        if (dec_valid) begin
          psel_d    = dec_sel;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_SETUP;
        end else begin
          state_d   = S_DERR;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (sel_ready) begin
          rdata_d   = pwrite_q ? '0 : sel_rdata;
          err_d     = 1'b0;
          psel_d    = '0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == CW'(TIMEOUT)) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            psel_d    = '0;
            penable_d = 1'b0;
            ack_d     = 1'b1;
            state_d   = S_RESP;
          end
        end
      end
      // Bus-free cycle for an undecodable address; keeps its ACK two cycles after REQ.
      S_DERR: begin
        rdata_d = '0;
        err_d   = 1'b1;
        ack_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign M_ACK     = ack_q;
  assign M_RDATA   = rdata_q;
  assign M_ERR     = err_q;
  assign M_BUSY    = busy_q;
  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;
  assign M_PWDATA  = pwdata_q;
endmodule

// File: tb/tb_vmicro16_apb_master.sv
// Directed table-driven bench for vmicro16_apb_master (TIMEOUT overridden to 4).
module tb_vmicro16_apb_master;
  import vmicro16_apb_master_pkg::*;

  localparam int SLAVES = 8;
  localparam int DW     = DATA_WIDTH;
  localparam int AW     = APB_WIDTH;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 M_REQ = 1'b0;
  logic                 M_WE = 1'b0;
  logic [AW-1:0]        M_ADDR = '0;
  logic [DW-1:0]        M_WDATA = '0;
  logic                 M_ACK;
  logic [DW-1:0]        M_RDATA;
  logic                 M_ERR;
  logic                 M_BUSY;
  logic [AW-1:0]        M_PADDR;
  logic                 M_PWRITE;
  logic [SLAVES-1:0]    M_PSELx;
  logic                 M_PENABLE;
  logic [DW-1:0]        M_PWDATA;
  logic [SLAVES*DW-1:0] M_PRDATA = '0;
  logic [SLAVES-1:0]    M_PREADY = '0;

  int checks = 0;
  int failures = 0;

  vmicro16_apb_master #(.SLAVES(SLAVES), .SEL_SHIFT(12), .SEL_BITS(4), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_ACK(M_ACK), .M_RDATA(M_RDATA), .M_ERR(M_ERR),
    .M_BUSY(M_BUSY), .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              we;
    logic [AW-1:0]     addr;
    logic [DW-1:0]     wdata;
    int                waits;     // ACCESS cycles the slave holds PREADY low
    logic [DW-1:0]     prdata;
    logic [SLAVES-1:0] exp_sel;
    logic [DW-1:0]     exp_rdata;
    logic              exp_err;
    int                exp_lat;   // edges from REQ sample to ACK visible
    int                exp_pen;
    int                exp_setup;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int  edges = 0;
    int  pen = 0;
    int  setup = 0;
    int  bad = 0;
    int  acc = 0;
    bit  done = 1'b0;
    M_REQ = 1'b1; M_WE = v.we; M_ADDR = v.addr; M_WDATA = v.wdata;
    for (int i = 0; i < SLAVES; i++) begin
      M_PRDATA[i*DW +: DW] = DW'($urandom);
      if (v.exp_sel[i]) M_PRDATA[i*DW +: DW] = v.prdata;
    end
    M_PREADY = SLAVES'($urandom) & ~v.exp_sel;
    while (!done && edges < 40) begin
      step();
      edges++;
      if (M_ACK) begin
        done = 1'b1;
        M_REQ = 1'b0;
      end else if (!M_BUSY) bad++;
      if (M_PSELx != '0) begin
        if (M_PSELx !== v.exp_sel || M_PADDR !== v.addr || M_PWDATA !== v.wdata ||
            M_PWRITE !== v.we) bad++;
        if (M_PENABLE) pen++; else setup++;
      end else if (M_PENABLE) bad++;
      M_PREADY = SLAVES'($urandom) & ~v.exp_sel;
      if (M_PENABLE) begin
        if (acc == v.waits) M_PREADY = M_PREADY | v.exp_sel;
        acc++;
      end
    end
    M_PREADY = '0;
    check({tag, " ack_seen"}, 64'(done), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'(v.exp_lat));
    check({tag, " rdata"}, 64'(M_RDATA), 64'(v.exp_rdata));
    check({tag, " err"}, 64'(M_ERR), 64'(v.exp_err));
    check({tag, " penable_cycles"}, 64'(pen), 64'(v.exp_pen));
    check({tag, " setup_cycles"}, 64'(setup), 64'(v.exp_setup));
    check({tag, " bus_violations"}, 64'(bad), 64'd0);
    step();
    check({tag, " idle_after_ack"}, {46'd0, M_ACK, M_BUSY, M_RDATA}, {48'd0, v.exp_rdata});
  endtask

  initial begin
    int n;
    bit seen;
    //          we    addr         wdata     waits prdata    sel    rdata    err lat pen setup
    vecs[0] = '{1'b0, 24'hC32ABC, 16'h0000, 0,   16'hBEEF, 8'h04, 16'hBEEF, 0, 3, 1, 1};
    vecs[1] = '{1'b1, 24'h800010, 16'h1234, 2,   16'h7777, 8'h01, 16'h0000, 0, 5, 3, 1};
    vecs[2] = '{1'b0, 24'h0D9000, 16'h0000, 0,   16'h0000, 8'h00, 16'h0000, 1, 2, 0, 0};
    vecs[3] = '{1'b0, 24'h005100, 16'h0000, 255, 16'h5555, 8'h20, 16'h0000, 1, 6, 4, 1};
    vecs[4] = '{1'b0, 24'h001004, 16'h0000, 0,   16'h1111, 8'h02, 16'h1111, 0, 3, 1, 1};
    vecs[5] = '{1'b0, 24'hFF3002, 16'h0000, 1,   16'h3333, 8'h08, 16'h3333, 0, 4, 2, 1};
    vecs[6] = '{1'b1, 24'h017FFE, 16'hABCD, 0,   16'h5A5A, 8'h80, 16'h0000, 0, 3, 1, 1};
    vecs[7] = '{1'b0, 24'h00F000, 16'h0000, 0,   16'h0000, 8'h00, 16'h0000, 1, 2, 0, 0};
    vecs[8] = '{1'b0, 24'h3C6008, 16'h0000, 3,   16'h0F0F, 8'h40, 16'h0F0F, 0, 6, 4, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {M_ACK, M_RDATA, M_ERR, M_BUSY, M_PADDR, M_PWRITE, M_PSELx,
                            M_PENABLE, M_PWDATA}, 64'd0);
    reset = 1'b1;
    step();
    check("idle_after_release", {M_ACK, M_BUSY, M_PSELx, M_PENABLE}, 64'd0);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort a transfer mid-ACCESS with an asynchronous reset.
    M_REQ = 1'b1; M_WE = 1'b0; M_ADDR = 24'h004200; M_PREADY = '0;
    n = 0;
    while (!M_PENABLE && n < 10) begin
      step();
      n++;
    end
    check("abort_reached_access", 64'(M_PENABLE), 64'd1);
    #2 reset = 1'b0;
    M_REQ = 1'b0;
    #1;
    check("abort_async_clear", {M_PSELx, M_PENABLE, M_BUSY, M_ACK}, 64'd0);
    seen = 1'b0;
    repeat (3) begin
      step();
      if (M_ACK) seen = 1'b1;
    end
    check("abort_no_ack", 64'(seen), 64'd0);
    reset = 1'b1;
    step();
    run_txn('{1'b0, 24'h004200, 16'h0000, 0, 16'h4444, 8'h10, 16'h4444, 0, 3, 1, 1},
            "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
